hazard_tracker: RTL and testbench
=================================

HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: d_rs, d_rt  input  5 each  D-stage source register numbers.
REQ-004 SHALL have ports: d_tuse1, d_tuse2  input  2 each  cycles until D instr needs rs/rt (3 = never used).
REQ-005 SHALL have ports: d_dst  input  5  D instr destination register (0 = no write).
REQ-006 SHALL have ports: d_tnew  input  2  cycles after entering E until D instr result is ready.
REQ-007 SHALL have ports: d_md_start, d_md_div, d_hilo_use  input  1 each  D instr is mult/div, is div/divu, touches HI/LO.
REQ-008 SHALL have ports: stall  output  1  freeze PC and F/D, inject bubble into E.
REQ-009 SHALL have ports: fwd_rs_sel, fwd_rt_sel  output  2 each  D-stage bypass source: 0 RF, 1 E, 2 M, 3 W.
REQ-010 SHALL have ports: md_busy  output  1  HI/LO unit busy; stall_cnt  output  16  total stall cycles since reset.

Function
REQ-011 SHALL keep three tracking slots E, M, W, each holding dst[4:0] and tnew[1:0].
REQ-012 SHALL update slots every clock: W<=M, M<=E, with tnew saturating-decremented by 1 (floor 0).
REQ-013 SHALL load E<={d_dst,d_tnew} when stall=0, and E<={0,0} (bubble) when stall=1.
REQ-014 SHALL define operand hazard for rs: d_rs!=0, youngest slot (E, then M, then W) with dst==d_rs has tnew>d_tuse1; same for rt with d_tuse2.
REQ-015 SHALL determine hazards from the youngest matching slot only; older matches are ignored.
REQ-016 SHALL drive fwd_rs_sel to the youngest matching slot when its tnew==0, else 0; same rule for fwd_rt_sel; register 0 always selects 0.
REQ-017 SHALL compute stall and fwd_*_sel combinationally from the current slot state and D inputs, with zero-cycle latency.
REQ-018 SHALL load an md counter when d_md_start=1 and stall=0: 5 for mult, 10 for div; it then decrements once per cycle to 0.
REQ-019 SHALL hold md_busy=1 while the counter is nonzero.
REQ-020 SHALL assert stall when d_hilo_use=1 and md_busy=1.
REQ-021 SHALL make stall the OR of rs hazard, rt hazard and the HI/LO condition.
REQ-022 SHALL let a new d_md_start while md_busy=1 be blocked by REQ-020, so the counter is never reloaded mid-count.
REQ-023 SHALL increment stall_cnt on every cycle with stall=1 and saturate it at 16'hFFFF.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, clear all slots to {0,0} and clear the md counter and stall_cnt to 0.
REQ-025 SHALL, after reset, output stall=0, md_busy=0, fwd_rs_sel=fwd_rt_sel=0, stall_cnt=0.
REQ-026 SHALL let reset take priority over every same-cycle update, including in the middle of a stall or md count.

Configuration
REQ-027 SHALL, with HILO_STALL_EN defined, implement REQ-018..REQ-022 as specified.
REQ-028 SHALL, without HILO_STALL_EN, ignore d_md_start, d_md_div and d_hilo_use, tie md_busy to 0, and generate stall from operand hazards only.

Verification
REQ-029 SHALL cover: lw (dst=2, tnew=2) then addu rs=2 (tuse1=1) -> stall=1 for 1 cycle, then stall=0 with fwd_rs_sel=0; stall_cnt=1.
REQ-030 SHALL cover: addu (dst=3, tnew=1) then beq rs=3 (tuse1=0) -> stall=1 for 1 cycle, then fwd_rs_sel=2.
REQ-031 SHALL cover: writer with dst=0 and tnew=2, then reader with rs=0 and tuse1=0 -> stall stays 0 and fwd_rs_sel=0.
REQ-032 SHALL cover: E and M both dst=4 (E tnew=1, M tnew=0), reader rt=4 with tuse2=1 -> stall=0 and fwd_rt_sel=0 (youngest slot wins).
REQ-033 SHALL cover, with HILO_STALL_EN: mult then mflo (d_hilo_use=1) -> md_busy=1 and stall=1 for 5 cycles; without the macro -> stall=0.
REQ-034 SHALL cover: reset asserted during the third cycle of a div stall -> next cycle stall=0, md_busy=0, stall_cnt=0.

Source files
------------

// File: rtl/hazard_tracker_if.sv
// ============================================================================
// hazard_tracker_if -- D-stage request / hazard-decision bundle for hazard_tracker
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_tracker_if;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_tuse1;
    logic [1:0]  d_tuse2;
    logic [4:0]  d_dst;
    logic [1:0]  d_tnew;
    logic        d_md_start;
    logic        d_md_div;
    logic        d_hilo_use;
    logic        stall;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic        md_busy;
    logic [15:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_tuse1, d_tuse2, d_dst, d_tnew,
               d_md_start, d_md_div, d_hilo_use,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse1, d_tuse2, d_dst, d_tnew,
               d_md_start, d_md_div, d_hilo_use,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_tracker.sv
// ============================================================================
// hazard_tracker -- E/M/W destination tracking, stall and D-stage bypass select.
// Optional HI/LO busy interlock enabled by defining HILO_STALL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_tracker (
    input  wire logic       clk,
    input  wire logic       reset,
    hazard_tracker_if.slave bus
);

    localparam logic [3:0] c_MULT_CYCLES = 4'd5;
    localparam logic [3:0] c_DIV_CYCLES  = 4'd10;

    // Slot index 0 = E, 1 = M, 2 = W; bypass select code is index + 1.
    logic [2:0][4:0] r_dst;
    logic [2:0][1:0] r_tnew;
    logic [15:0]     r_stall_cnt;

    logic [2:0] w_chk_rs;
    logic [2:0] w_chk_rt;
    logic       w_md_busy;
    logic       w_hilo_stall;
    logic       w_stall;

    // Returns {hazard, fwd_sel} from the youngest slot whose dst matches src.
    function automatic logic [2:0] f_check(
        input logic [4:0]      src,
        input logic [1:0]      tuse,
        input logic [2:0][4:0] dst,
        input logic [2:0][1:0] tnew
    );
        logic [2:0] res;
        res = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            if (dst[k] == src) begin
                res = {(tnew[k] > tuse), ((tnew[k] == 2'd0) ? 2'(k + 1) : 2'd0)};
            end
        end
        if (src == 5'd0) begin
            res = 3'd0;
        end
        return res;
    endfunction

    function automatic logic [1:0] f_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    assign w_chk_rs = f_check(bus.d_rs, bus.d_tuse1, r_dst, r_tnew);
    assign w_chk_rt = f_check(bus.d_rt, bus.d_tuse2, r_dst, r_tnew);

`ifdef HILO_STALL_EN
    logic [3:0] r_md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= 4'd0;
        end else if (bus.d_md_start && !w_stall) begin
            r_md_cnt <= bus.d_md_div ? c_DIV_CYCLES : c_MULT_CYCLES;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    assign w_md_busy    = (r_md_cnt != 4'd0);
    assign w_hilo_stall = bus.d_hilo_use && w_md_busy;
`else
    logic w_unused_md;
    assign w_unused_md  = ^{bus.d_md_start, bus.d_md_div, bus.d_hilo_use,
                            c_MULT_CYCLES, c_DIV_CYCLES};
    assign w_md_busy    = 1'b0;
    assign w_hilo_stall = 1'b0;
`endif

    assign w_stall = w_chk_rs[2] | w_chk_rt[2] | w_hilo_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dst       <= '0;
            r_tnew      <= '0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_dst[0]  <= w_stall ? 5'd0 : bus.d_dst;
            r_tnew[0] <= w_stall ? 2'd0 : bus.d_tnew;
            r_dst[1]  <= r_dst[0];
            r_tnew[1] <= f_dec(r_tnew[0]);
            r_dst[2]  <= r_dst[1];
            r_tnew[2] <= f_dec(r_tnew[1]);
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign bus.stall      = w_stall;
    assign bus.fwd_rs_sel = w_chk_rs[1:0];
    assign bus.fwd_rt_sel = w_chk_rt[1:0];
    assign bus.md_busy    = w_md_busy;
    assign bus.stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_tracker.sv
// ============================================================================
// tb_hazard_tracker -- directed vector table, multi-cycle HI/LO sequences and
// randomized stimulus against an instruction-history reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_tracker;

    logic clk;
    logic reset;
    hazard_tracker_if bus ();

    hazard_tracker u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: last three instructions issued into E (bubbles have dst 0),
    // each stored with the tnew it had on entry; slot k has aged k cycles.
    int h_dst  [3];
    int h_tnew [3];
    int cyc     = 0;
    int md_last = -1;
    int m_cnt   = 0;
    logic       m_stall, m_busy;
    logic [1:0] m_fs, m_ft;

    typedef struct {
        logic [4:0]  rs;
        logic [1:0]  tu1;
        logic [4:0]  rt;
        logic [1:0]  tu2;
        logic [4:0]  dst;
        logic [1:0]  tnew;
        logic        stall;
        logic [1:0]  fs;
        logic [1:0]  ft;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(int rs, int tu1, int rt, int tu2, int dst, int tnew,
                                int st, int fs, int ft, int cnt);
        vec_t v;
        v.rs = 5'(rs); v.tu1 = 2'(tu1); v.rt = 5'(rt); v.tu2 = 2'(tu2);
        v.dst = 5'(dst); v.tnew = 2'(tnew);
        v.stall = 1'(st); v.fs = 2'(fs); v.ft = 2'(ft); v.cnt = 16'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(int rs, int tu1, int rt, int tu2, int dst, int tnew,
                         int start, int dv, int hilo);
        bus.d_rs = 5'(rs); bus.d_tuse1 = 2'(tu1);
        bus.d_rt = 5'(rt); bus.d_tuse2 = 2'(tu2);
        bus.d_dst = 5'(dst); bus.d_tnew = 2'(tnew);
        bus.d_md_start = 1'(start); bus.d_md_div = 1'(dv); bus.d_hilo_use = 1'(hilo);
    endtask

    task automatic nop();
        drive(0, 3, 0, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input int src, input int tuse, output logic haz, output logic [1:0] sel);
        int eff;
        haz = 1'b0;
        sel = 2'd0;
        if (src != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (h_dst[k] == src) begin
                    eff = h_tnew[k] - k;
                    if (eff < 0) eff = 0;
                    haz = (eff > tuse);
                    sel = (eff == 0) ? 2'(k + 1) : 2'd0;
                    break;
                end
            end
        end
    endtask

    task automatic model_eval();
        logic hrs, hrt;
        lookup(int'(bus.d_rs), int'(bus.d_tuse1), hrs, m_fs);
        lookup(int'(bus.d_rt), int'(bus.d_tuse2), hrt, m_ft);
`ifdef HILO_STALL_EN
        m_busy = (cyc <= md_last);
`else
        m_busy = 1'b0;
`endif
        m_stall = hrs | hrt | (bus.d_hilo_use & m_busy);
    endtask

    task automatic model_commit();
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                h_dst[k] = 0; h_tnew[k] = 0;
            end
            md_last = -1;
            m_cnt   = 0;
        end else begin
            if (m_stall && m_cnt < 65535) m_cnt++;
`ifdef HILO_STALL_EN
            if (bus.d_md_start && !m_stall) md_last = cyc + (bus.d_md_div ? 10 : 5);
`endif
            h_dst[2] = h_dst[1]; h_tnew[2] = h_tnew[1];
            h_dst[1] = h_dst[0]; h_tnew[1] = h_tnew[0];
            h_dst[0] = m_stall ? 0 : int'(bus.d_dst);
            h_tnew[0] = m_stall ? 0 : int'(bus.d_tnew);
        end
        cyc++;
    endtask

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Directed stream applied back-to-back right after reset.
        tbl[0]  = mk(0,3,0,3,0,0, 0,0,0,0);
        tbl[1]  = mk(0,3,0,3,2,2, 0,0,0,0);   // lw $2
        tbl[2]  = mk(2,1,0,3,5,1, 1,0,0,0);   // addu uses $2: load-use stall
        tbl[3]  = mk(2,1,0,3,5,1, 0,0,0,1);
        tbl[4]  = mk(0,3,0,3,0,0, 0,0,0,1);
        tbl[5]  = mk(0,3,0,3,0,0, 0,0,0,1);
        tbl[6]  = mk(0,3,0,3,0,0, 0,0,0,1);
        tbl[7]  = mk(0,3,0,3,3,1, 0,0,0,1);   // addu $3
        tbl[8]  = mk(3,0,0,3,0,0, 1,0,0,1);   // beq $3 needs it in D
        tbl[9]  = mk(3,0,0,3,0,0, 0,2,0,2);   // bypass from M
        tbl[10] = mk(3,0,0,3,0,0, 0,3,0,2);   // bypass from W
        tbl[11] = mk(0,3,0,3,0,2, 0,0,0,2);   // writer to $0
        tbl[12] = mk(0,0,0,3,0,0, 0,0,0,2);
        tbl[13] = mk(0,3,0,3,0,0, 0,0,0,2);
        tbl[14] = mk(0,3,0,3,4,1, 0,0,0,2);
        tbl[15] = mk(0,3,0,3,4,1, 0,0,0,2);
        tbl[16] = mk(0,3,4,1,0,0, 0,0,0,2);   // E and M both $4: E wins
        tbl[17] = mk(0,3,4,0,0,0, 0,0,2,2);
        tbl[18] = mk(4,0,4,0,0,0, 0,3,3,2);
        tbl[19] = mk(0,3,0,3,6,3, 0,0,0,2);
        tbl[20] = mk(0,3,6,2,0,0, 1,0,0,2);   // rt hazard, tnew 3 > tuse 2
        tbl[21] = mk(0,3,6,2,0,0, 0,0,0,3);   // tnew == tuse: no stall

        do_reset();
        #1;
        check("reset_stall",     {15'd0, bus.stall},      16'd0);
        check("reset_md_busy",   {15'd0, bus.md_busy},    16'd0);
        check("reset_fwd_rs",    {14'd0, bus.fwd_rs_sel}, 16'd0);
        check("reset_fwd_rt",    {14'd0, bus.fwd_rt_sel}, 16'd0);
        check("reset_stall_cnt", bus.stall_cnt,           16'd0);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rs, tbl[i].tu1, tbl[i].rt, tbl[i].tu2, tbl[i].dst, tbl[i].tnew, 0, 0, 0);
            #2;
            check($sformatf("vec%0d_stall", i), {15'd0, bus.stall},      {15'd0, tbl[i].stall});
            check($sformatf("vec%0d_fwd_rs", i), {14'd0, bus.fwd_rs_sel}, {14'd0, tbl[i].fs});
            check($sformatf("vec%0d_fwd_rt", i), {14'd0, bus.fwd_rt_sel}, {14'd0, tbl[i].ft});
            check($sformatf("vec%0d_cnt", i),    bus.stall_cnt,           tbl[i].cnt);
            tick();
        end

        // mult followed by mflo
        do_reset();
        drive(0, 3, 0, 3, 0, 0, 1, 0, 1);
        #2;
        check("mult_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            logic e;
`ifdef HILO_STALL_EN
            e = (i < 5);
`else
            e = 1'b0;
`endif
            drive(0, 3, 0, 3, 8, 1, 0, 0, 1);
            #2;
            check($sformatf("mflo%0d_stall", i), {15'd0, bus.stall},   {15'd0, e});
            check($sformatf("mflo%0d_busy", i),  {15'd0, bus.md_busy}, {15'd0, e});
            tick();
        end

        // div then mflo, reset during the third stall cycle
        do_reset();
        drive(0, 3, 0, 3, 0, 0, 1, 1, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            logic e;
`ifdef HILO_STALL_EN
            e = 1'b1;
`else
            e = 1'b0;
`endif
            drive(0, 3, 0, 3, 8, 1, 0, 0, 1);
            #2;
            check($sformatf("div%0d_stall", i), {15'd0, bus.stall}, {15'd0, e});
            if (i == 2) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        #2;
        check("divrst_stall", {15'd0, bus.stall},   16'd0);
        check("divrst_busy",  {15'd0, bus.md_busy}, 16'd0);
        check("divrst_cnt",   bus.stall_cnt,        16'd0);
        tick();

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int st;
            st = ($urandom_range(0, 15) == 0) ? 1 : 0;
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  st, $urandom_range(0, 1), (st == 1) ? 1 : (($urandom_range(0, 3) == 0) ? 1 : 0));
            reset = ($urandom_range(0, 299) == 0);
            #2;
            model_eval();
            check("rnd_stall",  {15'd0, bus.stall},      {15'd0, m_stall});
            check("rnd_fwd_rs", {14'd0, bus.fwd_rs_sel}, {14'd0, m_fs});
            check("rnd_fwd_rt", {14'd0, bus.fwd_rt_sel}, {14'd0, m_ft});
            check("rnd_busy",   {15'd0, bus.md_busy},    {15'd0, m_busy});
            check("rnd_cnt",    bus.stall_cnt,           16'(m_cnt));
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
